// File: rtl/rv32i_regfile_pkg.sv
// Shared constants and types for the RV32I register-file responder.
package rv32i_regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_BUSY = 2'd1,
    HS_RESP = 2'd2
  } hs_state_t;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

endpackage

// File: rtl/rv32i_regfile_handshake.sv
// Four-phase request/valid responder FSM, one instance per register-file port.
// state   | meaning
// HS_IDLE | waiting for req; accept pulses when req is seen
// HS_BUSY | one-cycle service slot; valid rises on the exiting edge
// HS_RESP | valid held until req drops
module rv32i_regfile_handshake
  import rv32i_regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic accept,
  output logic busy,
  output logic valid
);

  hs_state_t state;

  assign accept = (state == HS_IDLE) && req;
  assign busy   = (state == HS_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HS_IDLE;
      valid <= 1'b0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (req) state <= HS_BUSY;
        end
        HS_BUSY: begin
          state <= HS_RESP;
          valid <= 1'b1;
        end
        HS_RESP: begin
          if (!req) begin
            state <= HS_IDLE;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= HS_IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rv32i_regfile_responder.sv
// RV32I integer register file with independent handshaked read and write ports.
// x0 reads as zero and ignores writes; same-edge read/write service forwards write data.
module rv32i_regfile_responder
  import rv32i_regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_reg_addr,
  output logic [XLEN-1:0]   o_reg_data,
  output logic              o_rd_valid,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_dest_addr,
  input  logic [XLEN-1:0]   i_dest_reg_data,
  output logic              o_wr_valid
);

  logic rd_accept, rd_busy;
  logic wr_accept, wr_busy;

  reg_addr_t rd_addr;
  reg_addr_t wr_addr;
  reg_data_t wr_data;
  reg_data_t regs [NUM_REGS];
  logic      fwd_hit;

  rv32i_regfile_handshake u_rd_hs (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    (i_rd_en),
    .accept (rd_accept),
    .busy   (rd_busy),
    .valid  (o_rd_valid)
  );

  rv32i_regfile_handshake u_wr_hs (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    (i_wr_en),
    .accept (wr_accept),
    .busy   (wr_busy),
    .valid  (o_wr_valid)
  );

  assign fwd_hit = wr_busy && (wr_addr == rd_addr) && (rd_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_addr    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      o_reg_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (rd_accept) rd_addr <= i_reg_addr;
      if (wr_accept) begin
        wr_addr <= i_dest_addr;
        wr_data <= i_dest_reg_data;
      end
      if (wr_busy && (wr_addr != '0)) regs[wr_addr] <= wr_data;
      if (rd_busy) begin
        if (fwd_hit)              o_reg_data <= wr_data;
        else if (rd_addr == '0)   o_reg_data <= '0;
        else                      o_reg_data <= regs[rd_addr];
      end
    end
  end

endmodule

// File: doc/rv32i_regfile_responder.md
# rv32i_regfile_responder

Responder end of the register-file request/valid protocol. Holds the 32 x 32-bit RV32I integer registers and services one read port and one write port, each with an independent four-phase enable/valid handshake. Any initiator drives it: the debug wrapper, or the multicycle core's decode and writeback stages. Its registers are the architectural register state of the multicycle core.

## Interface
- XLEN, 32, register data width
- NUM_REGS, 32, register count; x0 is included and hardwired to zero
- ADDR_W, 5, register address width (log2 NUM_REGS)

- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_rd_en  in  1  read request; level, held until o_rd_valid is seen
- i_reg_addr  in  ADDR_W  read address; sampled only at acceptance
- o_reg_data  out  XLEN  read data; registered
- o_rd_valid  out  1  read response valid; registered level
- i_wr_en  in  1  write request; level, held until o_wr_valid is seen
- i_dest_addr  in  ADDR_W  write address; sampled at acceptance
- i_dest_reg_data  in  XLEN  write data; sampled at acceptance
- o_wr_valid  out  1  write complete; registered level

## Operation
- Each port has its own FSM: IDLE -> BUSY -> RESP -> IDLE.
- Read port:
  - IDLE & i_rd_en: latch i_reg_addr, go to BUSY.
  - BUSY: load o_reg_data with the register value (0 for x0), set o_rd_valid, go to RESP.
  - RESP: hold the data and o_rd_valid while i_rd_en=1. When i_rd_en=0, clear o_rd_valid and go to IDLE.
- Write port:
  - IDLE & i_wr_en: latch address and data, go to BUSY.
  - BUSY: commit to the array (skipped if address is 0), set o_wr_valid, go to RESP.
  - RESP: hold o_wr_valid while i_wr_en=1. When i_wr_en=0, clear it and go to IDLE.
- Write to x0: the handshake completes normally and nothing is stored.
- Forwarding: if the read BUSY cycle and the write BUSY cycle fall on the same edge with the same nonzero address, o_reg_data takes the write data.
- o_reg_data holds its last value after RESP and is not cleared until the next read or reset.
- Inputs sampled outside acceptance are ignored. Changing the address or data during BUSY or RESP has no effect.
- The two ports are fully independent. Simultaneous acceptance on both ports is legal.

## Timing
- Read latency: request sampled at edge E0, o_rd_valid=1 and data valid after E1. Minimum 2 edges.
- Write latency: accepted at E0, committed and o_wr_valid=1 after E1. The written value is visible to a read accepted at E0 or later (via forwarding when the BUSY cycles coincide).
- Back-to-back requests: after the enable drops, one IDLE cycle is required. The next acceptance is no earlier than 1 edge after the valid falls.
- Reset values: o_reg_data=0, o_rd_valid=0, o_wr_valid=0, both FSMs IDLE, all registers 0.
- Reset mid-operation: i_rst has priority over every transition.
  - A write in BUSY at the reset edge is dropped, with no commit.
  - Valids drop on that edge.
  - Enables still high after reset are accepted as new requests on the first non-reset edge.

## Structure
- Package rv32i_regfile_pkg holds:
  - XLEN, NUM_REGS, ADDR_W constants
  - typedef enum hs_state_t {HS_IDLE, HS_BUSY, HS_RESP}
  - typedef reg_addr_t = logic [ADDR_W-1:0]
- Sub-module rv32i_regfile_handshake implements the generic four-phase FSM (inputs: req; outputs: accept pulse, busy pulse, valid level). It is instantiated once per port. The array, x0 masking and forwarding stay in the top module.

## Test plan
- Reset then read x5 -> o_rd_valid rises 2 edges after acceptance, o_reg_data=0x00000000.
- Write x7=0xDEADBEEF, drop i_wr_en, then read x7 -> o_wr_valid pulse-level seen; read returns 0xDEADBEEF.
- Write x0=0xFFFFFFFF, then read x0 -> o_wr_valid asserts; read returns 0x00000000.
- Read x9 and write x9=0x12345678 accepted on the same edge, with x9 previously 0xA5A5A5A5 -> read returns 0x12345678.
- Write x3=0x1 with i_rst asserted on the BUSY edge, then read x3 -> o_wr_valid never asserts; read returns 0.
- Hold i_rd_en high for 10 cycles, changing i_reg_addr mid-RESP -> o_reg_data and o_rd_valid are stable for all 10 cycles. o_rd_valid falls 1 edge after i_rd_en drops, and the data value is retained.
